// File: rtl/sig_dump_ctrl_pkg.sv
// Shared constants, FSM encoding and address helper for the signature unloader.
package sig_dump_ctrl_pkg;

  // Byte address of DataCatch word 0.
  localparam logic [31:0] DCATCH_START_ADDR = 32'h0000_1000;

  // Offsets of the signature control words from the signature base.
  localparam logic [31:0] SIG_BEGIN_OFS = 32'h0000_0008;
  localparam logic [31:0] SIG_END_OFS   = 32'h0000_000C;
  localparam logic [31:0] SIG_FLAG_OFS  = 32'h0000_0010;

  // Only this exact value written to the flag word starts a dump.
  localparam logic [31:0] SIG_FLAG_VALUE = 32'h0000_0001;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_SEND,
    ST_DONE
  } dump_state_e;

  // Byte address to DataCatch word index; the two low address bits drop out in the shift.
  function automatic logic [31:0] word_index(input logic [31:0] addr, input logic [31:0] base);
    return (addr - base) >> 2;
  endfunction

endpackage

// File: rtl/sig_dump_ctrl_if.sv
// Snoop bus, DataCatch read port and signature stream of the unloader.
interface sig_dump_ctrl_if #(
  parameter int DCATCH_DEPTH = 2048
);
  localparam int AW = $clog2(DCATCH_DEPTH);

  logic          mem_we;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_wdata;
  logic          dc_rd_en;
  logic [AW-1:0] dc_rd_addr;
  logic [31:0]   dc_rd_data;
  logic          sig_valid;
  logic          sig_ready;
  logic [31:0]   sig_data;
  logic          sig_last;
  logic          done;
  logic          timeout;
  logic          err;

  // Unloader side.
  modport master (
    input  mem_we, mem_addr, mem_wdata, dc_rd_data, sig_ready,
    output dc_rd_en, dc_rd_addr, sig_valid, sig_data, sig_last, done, timeout, err
  );

  // Core, DataCatch and downstream sink side.
  modport slave (
    output mem_we, mem_addr, mem_wdata, dc_rd_data, sig_ready,
    input  dc_rd_en, dc_rd_addr, sig_valid, sig_data, sig_last, done, timeout, err
  );

endinterface

// File: rtl/sig_dump_ctrl_watchdog.sv
// Saturating cycle counter; expire is high while enabled at the terminal count.
module sig_watchdog #(
  parameter int LIMIT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expire
);
  localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [CW-1:0] MAX_COUNT = CW'(LIMIT - 1);

  logic [CW-1:0] count;

  // Count enabled cycles and hold at the terminal value.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every register updates from pre-edge values.
    if (rst || clear) begin
      count <= '0;
    end else if (en && (count != MAX_COUNT)) begin
      count <= count + CW'(1);
    end
  end

  assign expire = en && (count == MAX_COUNT);

endmodule

// File: rtl/sig_dump_ctrl.sv
// End-of-test signature unloader: snoops control words, reads the window, streams it out.
module sig_dump_ctrl
  import sig_dump_ctrl_pkg::*;
#(
  parameter logic [31:0] DCATCH_BASE    = DCATCH_START_ADDR,
  parameter int          DCATCH_DEPTH   = 2048,
  parameter logic [31:0] SIG_BASE       = 32'h1000_0000,
  parameter int          TIMEOUT_CYCLES = 1024
) (
  input logic            clk,
  input logic            rst,
  sig_dump_ctrl_if.master bus
);
  localparam int AW = $clog2(DCATCH_DEPTH);
  localparam logic [31:0] WINDOW_END = DCATCH_BASE + 32'(4 * DCATCH_DEPTH);

  dump_state_e   state_q, state_d;
  logic [31:0]   begin_reg, end_reg;
  logic [AW-1:0] ptr, last_idx;
  logic [31:0]   sig_data_q;
  logic          done_q, timeout_q, err_q;

  logic          in_idle, begin_we, end_we, flag_hit, wd_expire, trigger;
  logic          window_empty, window_bad, at_last, handshake;
  logic [AW-1:0] begin_idx, last_idx_d;

  assign in_idle   = (state_q == ST_IDLE);
  assign begin_we  = in_idle && bus.mem_we && (bus.mem_addr == SIG_BASE + SIG_BEGIN_OFS);
  assign end_we    = in_idle && bus.mem_we && (bus.mem_addr == SIG_BASE + SIG_END_OFS);
  assign flag_hit  = in_idle && bus.mem_we && (bus.mem_addr == SIG_BASE + SIG_FLAG_OFS)
                     && (bus.mem_wdata == SIG_FLAG_VALUE);

  // Empty check wins over the range check so a degenerate window never flags err.
  assign window_empty = (begin_reg >= end_reg);
  assign window_bad   = (begin_reg < DCATCH_BASE) || (end_reg > WINDOW_END);
  assign begin_idx    = AW'(word_index(begin_reg, DCATCH_BASE));
  assign last_idx_d   = AW'(word_index(end_reg, DCATCH_BASE) - 32'd1);

  assign at_last   = (ptr == last_idx);
  assign handshake = (state_q == ST_SEND) && bus.sig_ready;

  sig_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_watchdog (
    .clk   (clk),
    .rst   (rst),
    .clear (trigger),
    .en    (in_idle),
    .expire(wd_expire)
  );

  // Next-state decode and stream/read-port outputs.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_d        = state_q;
    trigger        = 1'b0;
    bus.dc_rd_en   = (state_q == ST_ISSUE);
    bus.dc_rd_addr = ptr;
    bus.sig_valid  = (state_q == ST_SEND);
    bus.sig_last   = (state_q == ST_SEND) && at_last;
    bus.sig_data   = sig_data_q;
    bus.done       = done_q;
    bus.timeout    = timeout_q;
    bus.err        = err_q;
    case (state_q)
      ST_IDLE: begin
        if (flag_hit || wd_expire) begin
          trigger = 1'b1;
          state_d = (window_empty || window_bad) ? ST_DONE : ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  state_d = ST_SEND;
      ST_SEND: begin
        if (bus.sig_ready) state_d = at_last ? ST_DONE : ST_ISSUE;
      end
      ST_DONE:  state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State register, snooped window, read pointer, output word and sticky status.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      begin_reg  <= '0;
      end_reg    <= '0;
      ptr        <= '0;
      last_idx   <= '0;
      sig_data_q <= '0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (begin_we) begin_reg <= bus.mem_wdata;
      if (end_we)   end_reg   <= bus.mem_wdata;
      if (trigger) begin
        // A flag write in the expiry cycle counts as a normal end of test.
        timeout_q <= !flag_hit;
        if (window_empty) begin
          done_q <= 1'b1;
        end else if (window_bad) begin
          err_q  <= 1'b1;
          done_q <= 1'b1;
        end else begin
          ptr      <= begin_idx;
          last_idx <= last_idx_d;
        end
      end
      if (state_q == ST_WAIT) sig_data_q <= bus.dc_rd_data;
      if (handshake) begin
        if (at_last) done_q <= 1'b1;
        else         ptr    <= ptr + AW'(1);
      end
    end
  end

endmodule

// File: tb/tb_sig_dump_ctrl.sv
// Directed self-checking bench for sig_dump_ctrl.
module tb_sig_dump_ctrl;
  import sig_dump_ctrl_pkg::*;

  localparam logic [31:0] SIG_BASE = 32'h1000_0000;
  localparam logic [31:0] A_BEGIN  = SIG_BASE + 32'h8;
  localparam logic [31:0] A_END    = SIG_BASE + 32'hC;
  localparam logic [31:0] A_FLAG   = SIG_BASE + 32'h10;

  typedef struct {
    logic [31:0] b;
    logic [31:0] e;
    int          ready_mode;
    int          n_words;
    logic [31:0] first_idx;
    logic        exp_err;
    string       tag;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  sig_dump_ctrl_if #(.DCATCH_DEPTH(2048)) bus ();

  sig_dump_ctrl dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int trig_cyc = 0;
  int rst_cyc  = 0;
  int ready_mode = 0;

  // Monitor state, owned by the negedge process below.
  logic [31:0] rx_data[$];
  logic        rx_last[$];
  int   rd_pulses = 0;
  int   first_valid_cyc = -1;
  int   done_cyc = -1;
  int   timeout_cyc = -1;
  int   stall_seen = 0;
  int   stall_bad = 0;
  bit   stalled = 1'b0;
  logic [31:0] held_data = '0;
  logic        held_last = 1'b0;

  vec_t vecs[10];

  always @(posedge clk) cyc++;

  // DataCatch model: one-cycle read latency, junk when not reading.
  always @(posedge clk)
    bus.dc_rd_data <= bus.dc_rd_en ? (32'hC0DE_0000 | 32'(bus.dc_rd_addr)) : 32'hDEAD_BEEF;

  // Downstream sink ready: always high, or 2 cycles low / 2 cycles high.
  initial begin
    int ph = 0;
    bus.sig_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      ph++;
      bus.sig_ready = (ready_mode == 0) ? 1'b1 : ph[1];
    end
  end

  // Observe the stream on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      rx_data.delete();
      rx_last.delete();
      rd_pulses = 0; first_valid_cyc = -1; done_cyc = -1; timeout_cyc = -1;
      stall_seen = 0; stall_bad = 0; stalled = 1'b0;
    end else begin
      if (stalled) begin
        stall_seen++;
        if (!bus.sig_valid || bus.sig_data !== held_data || bus.sig_last !== held_last) stall_bad++;
      end
      stalled   = bus.sig_valid && !bus.sig_ready;
      held_data = bus.sig_data;
      held_last = bus.sig_last;
      if (bus.sig_valid && bus.sig_ready) begin
        rx_data.push_back(bus.sig_data);
        rx_last.push_back(bus.sig_last);
      end
      if (bus.dc_rd_en) rd_pulses++;
      if (bus.sig_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (bus.done && done_cyc < 0) done_cyc = cyc;
      if (bus.timeout && timeout_cyc < 0) timeout_cyc = cyc;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    rst_cyc = cyc;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    bus.mem_we    = 1'b1;
    bus.mem_addr  = addr;
    bus.mem_wdata = data;
    @(posedge clk); #1;
    bus.mem_we = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n = 0;
    while (!bus.done && n < budget) begin @(posedge clk); #1; n++; end
    check({tag, "_done"}, 32'(bus.done), 1);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic check_dump(input string tag, input int n, input logic [31:0] first);
    check({tag, "_word_count"}, rx_data.size(), n);
    for (int k = 0; k < rx_data.size() && k < n; k++) begin
      check($sformatf("%s_data%0d", tag, k), rx_data[k], 32'hC0DE_0000 | (first + 32'(k)));
      check($sformatf("%s_last%0d", tag, k), 32'(rx_last[k]), (k == n - 1) ? 1 : 0);
    end
    check({tag, "_rd_pulses"}, rd_pulses, n);
    check({tag, "_stall_hold"}, stall_bad, 0);
  endtask

  task automatic run_row(input vec_t v);
    ready_mode = v.ready_mode;
    do_reset();
    bus_write(A_BEGIN, v.b);
    bus_write(A_END, v.e);
    trig_cyc = cyc;
    bus_write(A_FLAG, SIG_FLAG_VALUE);
    wait_done(800, v.tag);
    check_dump(v.tag, v.n_words, v.first_idx);
    check({v.tag, "_err"}, 32'(bus.err), 32'(v.exp_err));
    check({v.tag, "_timeout"}, 32'(bus.timeout), 0);
    if (v.n_words == 0) check({v.tag, "_done_latency"}, done_cyc - trig_cyc, 1);
    else                check({v.tag, "_valid_latency"}, first_valid_cyc - trig_cyc, 3);
    if (v.ready_mode != 0) check({v.tag, "_stalls_seen"}, 32'(stall_seen != 0), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    bus.mem_we = 1'b0; bus.mem_addr = '0; bus.mem_wdata = '0;

    vecs[0] = '{32'h2000, 32'h2090, 0, 36, 32'h400, 1'b0, "normal"};
    vecs[1] = '{32'h2000, 32'h2090, 1, 36, 32'h400, 1'b0, "backpressure"};
    vecs[2] = '{32'h2040, 32'h2040, 0,  0, 32'h0,   1'b0, "empty"};
    vecs[3] = '{32'h2000, 32'h5000, 0,  0, 32'h0,   1'b1, "end_beyond"};
    vecs[4] = '{32'h0800, 32'h1010, 0,  0, 32'h0,   1'b1, "begin_below"};
    vecs[5] = '{32'h2090, 32'h2000, 0,  0, 32'h0,   1'b0, "reversed"};
    vecs[6] = '{32'h2FF0, 32'h3000, 0,  4, 32'h7FC, 1'b0, "top_edge"};
    vecs[7] = '{32'h2FF0, 32'h3004, 0,  0, 32'h0,   1'b1, "top_over"};
    vecs[8] = '{32'h1000, 32'h1008, 1,  2, 32'h0,   1'b0, "bottom_edge"};
    vecs[9] = '{32'h2003, 32'h2012, 0,  4, 32'h400, 1'b0, "unaligned"};

    // Reset state.
    do_reset();
    check("reset_flags", 32'({bus.sig_valid, bus.sig_last, bus.dc_rd_en, bus.done, bus.timeout, bus.err}), 0);
    check("reset_data", bus.sig_data, 0);
    check("reset_rd_addr", 32'(bus.dc_rd_addr), 0);

    foreach (vecs[i]) run_row(vecs[i]);

    // Watchdog forces the dump of a preloaded window.
    ready_mode = 0;
    do_reset();
    bus_write(A_BEGIN, 32'h2000);
    bus_write(A_END, 32'h2010);
    wait_done(1200, "wd");
    check("wd_timeout", 32'(bus.timeout), 1);
    check("wd_expiry_cycle", timeout_cyc - rst_cyc, 1024);
    check("wd_err", 32'(bus.err), 0);
    check_dump("wd", 4, 32'h400);

    // Flag write in the expiry cycle wins over the watchdog.
    do_reset();
    bus_write(A_BEGIN, 32'h2000);
    bus_write(A_END, 32'h2010);
    while (cyc < rst_cyc + 1023) begin @(posedge clk); #1; end
    trig_cyc = cyc;
    bus_write(A_FLAG, SIG_FLAG_VALUE);
    wait_done(300, "wd_tie");
    check("wd_tie_timeout", 32'(bus.timeout), 0);
    check("wd_tie_valid_latency", first_valid_cyc - trig_cyc, 3);
    check_dump("wd_tie", 4, 32'h400);

    // Reset after the 10th word, then a fresh dump from word 0.
    do_reset();
    bus_write(A_BEGIN, 32'h2000);
    bus_write(A_END, 32'h2090);
    bus_write(A_FLAG, SIG_FLAG_VALUE);
    n = 0;
    while (rx_data.size() < 10 && n < 200) begin @(posedge clk); #1; n++; end
    check("rst_mid_words_before", rx_data.size(), 10);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_flags", 32'({bus.sig_valid, bus.sig_last, bus.dc_rd_en, bus.done, bus.timeout, bus.err}), 0);
    check("rst_mid_data", bus.sig_data, 0);
    check("rst_mid_rd_addr", 32'(bus.dc_rd_addr), 0);
    rst = 1'b0;
    rst_cyc = cyc;
    bus_write(A_BEGIN, 32'h2000);
    bus_write(A_END, 32'h2090);
    trig_cyc = cyc;
    bus_write(A_FLAG, SIG_FLAG_VALUE);
    wait_done(400, "restart");
    check("restart_valid_latency", first_valid_cyc - trig_cyc, 3);
    check_dump("restart", 36, 32'h400);

    // Control-word rewrites during SEND leave the running dump alone.
    do_reset();
    bus_write(A_BEGIN, 32'h2000);
    bus_write(A_END, 32'h2090);
    bus_write(A_FLAG, SIG_FLAG_VALUE);
    n = 0;
    while (!bus.sig_valid && n < 20) begin @(posedge clk); #1; n++; end
    check("rewrite_in_send", 32'(bus.sig_valid), 1);
    bus_write(A_BEGIN, 32'h2400);
    bus_write(A_END, 32'h2800);
    bus_write(A_FLAG, SIG_FLAG_VALUE);
    wait_done(400, "rewrite");
    check_dump("rewrite", 36, 32'h400);

    // Wrong flag value and an unstrobed flag write do not start a dump.
    do_reset();
    bus_write(A_BEGIN, 32'h2000);
    bus_write(A_END, 32'h2090);
    bus_write(A_FLAG, 32'h2);
    bus.mem_addr = A_FLAG; bus.mem_wdata = SIG_FLAG_VALUE;
    repeat (20) begin @(posedge clk); #1; end
    check("flag_ignored_done", 32'(bus.done), 0);
    check("flag_ignored_reads", rd_pulses, 0);
    trig_cyc = cyc;
    bus_write(A_FLAG, SIG_FLAG_VALUE);
    wait_done(400, "flag_after");
    check_dump("flag_after", 36, 32'h400);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
